alu_fpu_issue_ctrl: RTL and testbench

- Sequencing controller in front of the combined integer/floating-point execute block.
- Accepts one operation at a time from decode over a valid/ready handshake and registers its operands and op code.
- Holds them stable on the execute inputs for an op-dependent number of cycles, then captures the execute result.
- Presents the result with its destination tag to writeback over a second valid/ready handshake; stalls decode while the unit is occupied.

---
 rtl/alu_fpu_issue_ctrl.sv | 119 +++++++++++
 tb/tb_alu_fpu_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_fpu_issue_ctrl.sv
// Issue/sequencing controller in front of the shared integer/FP execute block.
// Accepts one op from decode, holds its operands on the execute inputs for an
// op-dependent latency, captures the result and presents it to writeback.
module alu_fpu_issue_ctrl #(
  parameter int unsigned ALU_LAT   = 1,
  parameter int unsigned FADD_LAT  = 3,
  parameter int unsigned FMUL_LAT  = 4,
  parameter int unsigned FDIV_LAT  = 12,
  parameter int unsigned FMISC_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_operand_a,
  input  logic [31:0] i_operand_b,
  input  logic [31:0] i_rs1_f,
  input  logic [31:0] i_rs2_f,
  input  logic [4:0]  i_alu_op,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_rd_is_fp,
  input  logic        i_flush,
  output logic [31:0] o_operand_a,
  output logic [31:0] o_operand_b,
  output logic [31:0] o_rs1_f,
  output logic [31:0] o_rs2_f,
  output logic [4:0]  o_alu_op,
  input  logic [31:0] i_alu_fpu_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic [4:0]  o_rsp_rd_addr,
  output logic        o_rsp_rd_is_fp,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       accept;

  // Latency minus one, loaded into the countdown on accept.
  function automatic logic [3:0] lat_m1(input logic [4:0] op);
    logic [3:0] r;
    if (!op[4])                             r = 4'(ALU_LAT - 1);
    else if (op == 5'b10000 || op == 5'b10001) r = 4'(FADD_LAT - 1);
    else if (op == 5'b10010)                r = 4'(FMUL_LAT - 1);
    else if (op == 5'b10011)                r = 4'(FDIV_LAT - 1);
    else                                    r = 4'(FMISC_LAT - 1);
    return r;
  endfunction

  // Ready depends only on state, writeback ready and flush (never on req_valid).
  always_comb begin
    o_req_ready = !i_flush && ((state == IDLE) || ((state == DONE) && i_rsp_ready));
    accept      = i_req_valid && o_req_ready;
    o_busy      = (state != IDLE);
  end

  // Sequencing FSM with registered operand, response and tag outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      cnt            <= '0;
      o_operand_a    <= '0;
      o_operand_b    <= '0;
      o_rs1_f        <= '0;
      o_rs2_f        <= '0;
      o_alu_op       <= '0;
      o_rsp_valid    <= 1'b0;
      o_rsp_data     <= '0;
      o_rsp_rd_addr  <= '0;
      o_rsp_rd_is_fp <= 1'b0;
    end else if (i_flush) begin
      state       <= IDLE;
      o_rsp_valid <= 1'b0;
    end else begin
      // Accept is only possible in IDLE or in DONE with the handshake, so the
      // load path is shared; a DONE accept also retires the held response.
      if (accept) begin
        o_operand_a    <= i_operand_a;
        o_operand_b    <= i_operand_b;
        o_rs1_f        <= i_rs1_f;
        o_rs2_f        <= i_rs2_f;
        o_alu_op       <= i_alu_op;
        o_rsp_rd_addr  <= i_rd_addr;
        o_rsp_rd_is_fp <= i_rd_is_fp;
        cnt            <= lat_m1(i_alu_op);
        o_rsp_valid    <= 1'b0;
        state          <= BUSY;
      end else begin
        case (state)
          BUSY: begin
            if (cnt == 4'd0) begin
              o_rsp_data  <= i_alu_fpu_data;
              o_rsp_valid <= 1'b1;
              state       <= DONE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          DONE: begin
            if (i_rsp_ready) begin
              o_rsp_valid <= 1'b0;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_fpu_issue_ctrl.sv
// Directed self-checking bench for alu_fpu_issue_ctrl.
module tb_alu_fpu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] operand_a, operand_b, rs1_f, rs2_f;
  logic [4:0]  alu_op, rd_addr;
  logic        rd_is_fp, flush;
  logic [31:0] x_a, x_b, x_rs1, x_rs2;
  logic [4:0]  x_op;
  logic [31:0] ex_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_is_fp, busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  alu_fpu_issue_ctrl dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_operand_a(operand_a), .i_operand_b(operand_b),
    .i_rs1_f(rs1_f), .i_rs2_f(rs2_f),
    .i_alu_op(alu_op), .i_rd_addr(rd_addr), .i_rd_is_fp(rd_is_fp),
    .i_flush(flush),
    .o_operand_a(x_a), .o_operand_b(x_b), .o_rs1_f(x_rs1), .o_rs2_f(x_rs2),
    .o_alu_op(x_op), .i_alu_fpu_data(ex_data),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_rd_addr(rsp_rd), .o_rsp_rd_is_fp(rsp_is_fp),
    .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Execute-block stand-in: integer ops add, FP ops return fixed hand results.
  always_comb begin
    ex_data = x_a + x_b;
    case (x_op)
      5'b10000: ex_data = 32'h4040_0000;  // 1.0 + 2.0 = 3.0
      5'b10010: ex_data = 32'h40C0_0000;  // 2.0 * 3.0 = 6.0
      5'b10011: ex_data = 32'h4000_0000;  // 4.0 / 2.0 = 2.0
      5'b10100: ex_data = x_rs1;          // move-like misc op
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] f1, input logic [31:0] f2,
                       input logic [4:0] rd, input logic fp);
    req_valid = 1'b1;
    alu_op = op; operand_a = a; operand_b = b; rs1_f = f1; rs2_f = f2;
    rd_addr = rd; rd_is_fp = fp;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; flush = 1'b0;
    operand_a = '0; operand_b = '0; rs1_f = '0; rs2_f = '0;
    alu_op = '0; rd_addr = '0; rd_is_fp = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_opa", x_a, 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    // Integer op, latency 1
    drive(5'b00000, 32'd5, 32'd7, '0, '0, 5'd3, 1'b0);
    tick();
    req_valid = 1'b0;
    chk("int_busy", {31'd0, busy}, 32'd1);
    chk("int_ready0", {31'd0, req_ready}, 32'd0);
    chk("int_valid0", {31'd0, rsp_valid}, 32'd0);
    chk("int_opa", x_a, 32'd5);
    tick();
    chk("int_valid", {31'd0, rsp_valid}, 32'd1);
    chk("int_data", rsp_data, 32'd12);
    chk("int_rd", {27'd0, rsp_rd}, 32'd3);
    chk("int_isfp", {31'd0, rsp_is_fp}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("int_idle", {31'd0, busy}, 32'd0);
    chk("int_valid_clr", {31'd0, rsp_valid}, 32'd0);

    // FDIV, latency 12; req_valid left high to confirm it is ignored
    drive(5'b10011, '0, '0, 32'h4080_0000, 32'h4000_0000, 5'd7, 1'b1);
    tick();
    alu_op = 5'b00000; rs1_f = 32'hDEAD_BEEF;
    for (int k = 1; k <= 11; k++) begin
      chk("fdiv_ready", {31'd0, req_ready}, 32'd0);
      chk("fdiv_valid", {31'd0, rsp_valid}, 32'd0);
      chk("fdiv_op", {27'd0, x_op}, 32'h13);
      chk("fdiv_rs1", x_rs1, 32'h4080_0000);
      tick();
    end
    chk("fdiv_valid_e11", {31'd0, rsp_valid}, 32'd0);
    req_valid = 1'b0;
    tick();
    chk("fdiv_valid_e12", {31'd0, rsp_valid}, 32'd1);
    chk("fdiv_data", rsp_data, 32'h4000_0000);
    chk("fdiv_rd", {27'd0, rsp_rd}, 32'd7);
    chk("fdiv_isfp", {31'd0, rsp_is_fp}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("fdiv_idle", {31'd0, busy}, 32'd0);

    // FMUL with back-pressure, then back-to-back FADD
    drive(5'b10010, '0, '0, 32'h4000_0000, 32'h4040_0000, 5'd9, 1'b1);
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    chk("fmul_valid_e3", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("fmul_valid_e4", {31'd0, rsp_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_data, 32'h40C0_0000);
      chk("bp_rd", {27'd0, rsp_rd}, 32'd9);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    drive(5'b10000, '0, '0, 32'h3F80_0000, 32'h4000_0000, 5'd4, 1'b1);
    #1;
    chk("b2b_ready", {31'd0, req_ready}, 32'd1);
    tick();
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("b2b_valid_clr", {31'd0, rsp_valid}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_rd", {27'd0, rsp_rd}, 32'd4);
    tick(); tick();
    chk("fadd_valid_e2", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("fadd_valid_e3", {31'd0, rsp_valid}, 32'd1);
    chk("fadd_data", rsp_data, 32'h4040_0000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Flush during FDIV
    drive(5'b10011, '0, '0, 32'h4080_0000, 32'h4000_0000, 5'd1, 1'b1);
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    #1;
    chk("flush_ready", {31'd0, req_ready}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_idle", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 12; k++) begin
      chk("flush_novalid", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    drive(5'b00000, 32'd100, 32'd23, '0, '0, 5'd2, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    chk("postflush_valid", {31'd0, rsp_valid}, 32'd1);
    chk("postflush_data", rsp_data, 32'd123);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Asynchronous reset during FADD
    drive(5'b10000, 32'd9, 32'd9, 32'h3F80_0000, 32'h4000_0000, 5'd6, 1'b1);
    tick();
    req_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_opa", x_a, 32'd0);
    chk("arst_rs1", x_rs1, 32'd0);
    chk("arst_op", {27'd0, x_op}, 32'd0);
    chk("arst_data", rsp_data, 32'd0);
    chk("arst_rd", {27'd0, rsp_rd}, 32'd0);
    chk("arst_isfp", {31'd0, rsp_is_fp}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("arst_novalid", {31'd0, rsp_valid}, 32'd0);
    end

    // FMISC decode: 10100 takes 2 cycles
    drive(5'b10100, '0, '0, 32'h1234_5678, 32'd0, 5'd8, 1'b1);
    tick();
    req_valid = 1'b0;
    tick();
    chk("fmisc_valid_e1", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("fmisc_valid_e2", {31'd0, rsp_valid}, 32'd1);
    chk("fmisc_data", rsp_data, 32'h1234_5678);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Op 01111 is integer: 1 cycle
    drive(5'b01111, 32'd10, 32'd3, 32'hFFFF_FFFF, '0, 5'd31, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    chk("int15_valid", {31'd0, rsp_valid}, 32'd1);
    chk("int15_data", rsp_data, 32'd13);
    chk("int15_rd", {27'd0, rsp_rd}, 32'd31);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
